instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream neighbour of Decoder: fetches 32-bit instruction words from program memory over a req/ack port.
//  Buffers fetched words in a small prefetch queue and presents the queue head on InstructionBus.
//  Supports PC redirect (jump) with queue flush and discard of an in-flight fetch.
// PARAMETERS
//  ADDR_W    16  program-memory word-address width; PC wraps modulo 2^ADDR_W
//  DATA_W    32  instruction width, matches Decoder InstructionBus
//  Q_DEPTH   2   prefetch queue entries (power of 2, >=2)
//  RESET_PC  0   PC value loaded at reset
// PORTS
//  clk            in   1        system clock, rising edge
//  rst            in   1        asynchronous, active-high reset
//  MemReq         out  1        fetch request to program memory
//  MemAddr        out  ADDR_W   fetch word address, stable while MemReq=1
//  MemAck         in   1        memory accepts request; MemData valid same cycle
//  MemData        in   DATA_W   fetched instruction word
//  JumpEn         in   1        one-cycle pulse: redirect PC
//  JumpAddr       in   ADDR_W   redirect target, sampled when JumpEn=1
//  DecReady       in   1        Decoder consumes head this cycle
//  InstructionBus out  DATA_W   queue head; 0 when queue empty
//  InstrValid     out  1        queue non-empty
//  InstrPC        out  ADDR_W   address of the head word
// BEHAVIOUR
//  Reset (async): MemReq=0, MemAddr=RESET_PC, InstructionBus=0, InstrValid=0, InstrPC=0,
//   queue empty, FSM=BOOT. rst mid-fetch aborts everything; a later MemAck is ignored until FETCH.
//  FSM: BOOT -> FETCH after one clk. FETCH: MemReq=1 iff (count + outstanding) < Q_DEPTH.
//   JumpEn while a request is outstanding and unacked -> DISCARD. DISCARD: MemReq stays 1 on the old addr
//   until MemAck; acked data is dropped; then FETCH at the jump target.
//  Handshake: one outstanding request max. MemReq/MemAddr are held until MemAck is sampled 1 at a rising edge.
//   On that edge: push {MemData, MemAddr}; MemAddr<=MemAddr+1 (wraps 2^ADDR_W-1 -> 0).
//   MemReq may stay 1 back-to-back, giving 1 word/cycle with a zero-wait memory.
//  Latency: ack at edge N -> InstrValid=1 and word on InstructionBus after edge N.
//   First MemReq=1 occurs 1 cycle after rst deasserts.
//  Pop: DecReady=1 && InstrValid=1 at edge -> advance head. DecReady with empty queue is ignored.
//  Push+pop in same edge: count unchanged. Overflow is impossible by the request rule.
//  Jump (JumpEn=1 at edge): queue flushed (InstrValid=0 next cycle); MemAddr<=JumpAddr. Jump beats push and pop.
//   A same-edge MemAck is dropped, the request is complete, and there is no DISCARD.
//   JumpEn during DISCARD updates the pending target; the last one wins.
//  Queue: circular buffer, wr/rd pointers log2(Q_DEPTH) bits, wrap silently; count 0..Q_DEPTH.
//  Outputs InstructionBus/InstrPC are driven from the registered head entry, not from MemData.
// CONFIGURATION
//  IFU_STALL_CNT_EN defined:
//   - extra output StallCnt out 16: increments each cycle DecReady=1 && InstrValid=0.
//   - saturates at 16'hFFFF; cleared by rst and by JumpEn.
//  Undefined: no StallCnt port, no counter logic; all other behaviour identical.
// TESTING
//  1 Reset release, memory acks every cycle, MemData=addr+32'h100, DecReady=1
//    -> MemAddr 0,1,2,...; InstructionBus 32'h100,32'h101,... one per cycle; InstrPC tracks.
//  2 DecReady=0, ack every cycle
//    -> exactly 2 acked fetches; MemReq=0 while full. Then DecReady=1 for 1 cycle -> MemReq=1 next cycle.
//  3 MemAck delayed 3 cycles on addr 5
//    -> MemReq=1 and MemAddr=5 held stable all 4 cycles; InstrValid=0 until ack.
//  4 JumpEn, JumpAddr=16'h0040, while addr 7 is outstanding
//    -> queue flushed; addr-7 data never appears; next pushed InstrPC=16'h0040.
//  5 MemAddr=16'hFFFF acked -> next MemAddr=16'h0000.
//    rst pulsed mid-wait -> all outputs reset; the stale ack is ignored.
//  6 (IFU_STALL_CNT_EN) DecReady=1, memory silent 10 cycles
//    -> StallCnt=10; JumpEn -> StallCnt=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: req/ack program-memory fetcher feeding a small prefetch queue for the Decoder.
// Optional macro IFU_STALL_CNT_EN adds the StallCnt output (decoder-starved cycle counter).
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 32,
  parameter int                Q_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData,
  input  logic              JumpEn,
  input  logic [ADDR_W-1:0] JumpAddr,
  input  logic              DecReady,
  output logic [DATA_W-1:0] InstructionBus,
  output logic              InstrValid,
  output logic [ADDR_W-1:0] InstrPC
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0]       StallCnt
`endif
);

  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam logic [PTR_W:0] QFULL = (PTR_W+1)'(Q_DEPTH);

  localparam logic [1:0] BOOT    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pendingAddr;
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic [PTR_W:0]    count;
  logic [DATA_W-1:0] dataMem [Q_DEPTH];
  logic [ADDR_W-1:0] pcMem   [Q_DEPTH];
  logic              accept;
  logic              push;
  logic              pop;

  // MemReq cannot drop before its ack: count only falls or flushes while a request waits.
  assign MemReq     = (state == DISCARD) || ((state == FETCH) && (count < QFULL));
  assign accept     = MemReq && MemAck;
  assign push       = (state == FETCH) && accept && !JumpEn;
  assign InstrValid = (count != '0);
  assign pop        = DecReady && InstrValid && !JumpEn;

  assign InstructionBus = InstrValid ? dataMem[rdPtr] : '0;
  assign InstrPC        = InstrValid ? pcMem[rdPtr]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      MemAddr     <= RESET_PC;
      pendingAddr <= RESET_PC;
    end else begin
      case (state)
        BOOT: begin
          state <= FETCH;
          if (JumpEn) MemAddr <= JumpAddr;
        end
        FETCH: begin
          if (JumpEn) begin
            if (MemReq && !MemAck) begin
              state       <= DISCARD;
              pendingAddr <= JumpAddr;
            end else begin
              MemAddr <= JumpAddr;
            end
          end else if (accept) begin
            MemAddr <= MemAddr + 1'b1;
          end
        end
        DISCARD: begin
          // The stale word is dropped here; a jump on the same edge still wins.
          if (MemAck) begin
            state   <= FETCH;
            MemAddr <= JumpEn ? JumpAddr : pendingAddr;
          end else if (JumpEn) begin
            pendingAddr <= JumpAddr;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (JumpEn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      dataMem[wrPtr] <= MemData;
      pcMem[wrPtr]   <= MemAddr;
    end
  end

`ifdef IFU_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCnt <= '0;
    end else if (JumpEn) begin
      StallCnt <= '0;
    end else if (DecReady && !InstrValid && (StallCnt != 16'hFFFF)) begin
      StallCnt <= StallCnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a randomized run
// against a transaction-level queue model of the fetch unit.
module tb_instruction_fetch_unit;

  localparam int QD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemAck = 1'b0;
  logic [31:0] MemData = '0;
  logic        JumpEn = 1'b0;
  logic [15:0] JumpAddr = '0;
  logic        DecReady = 1'b0;
  logic [31:0] InstructionBus;
  logic        InstrValid;
  logic [15:0] InstrPC;
`ifdef IFU_STALL_CNT_EN
  logic [15:0] StallCnt;
`endif

  int checkCnt = 0;
  int passCnt  = 0;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemData(MemData),
    .JumpEn(JumpEn), .JumpAddr(JumpAddr), .DecReady(DecReady),
    .InstructionBus(InstructionBus), .InstrValid(InstrValid), .InstrPC(InstrPC)
`ifdef IFU_STALL_CNT_EN
    , .StallCnt(StallCnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a list of fetched {data, pc} words, the next fetch address and a discard flag.
  bit          mBooted;
  bit          mDiscard;
  logic [15:0] mAddr;
  logic [15:0] mPending;
  logic [47:0] mQ[$];
  int          mStall;

  function automatic void modelReset();
    mBooted = 0; mDiscard = 0; mAddr = 16'h0; mPending = 16'h0; mQ.delete(); mStall = 0;
  endfunction

  function automatic bit expReq();
    return mBooted && (mDiscard || (mQ.size() < QD));
  endfunction

  function automatic void modelEdge(input bit ack, input bit jmp, input logic [15:0] ja, input bit dec);
    bit req;
    logic [31:0] word;
    req = expReq();
    if (jmp) mStall = 0;
    else if (dec && mQ.size() == 0 && mStall < 65535) mStall++;
    if (!mBooted) begin
      mBooted = 1;
      if (jmp) mAddr = ja;
    end else if (mDiscard) begin
      if (ack) begin
        mDiscard = 0;
        mAddr = jmp ? ja : mPending;
      end else if (jmp) mPending = ja;
    end else if (jmp) begin
      mQ.delete();
      if (req && !ack) begin
        mDiscard = 1;
        mPending = ja;
      end else mAddr = ja;
    end else begin
      if (dec && mQ.size() > 0) void'(mQ.pop_front());
      if (req && ack) begin
        word = {16'h0, mAddr} + 32'h100;
        mQ.push_back({word, mAddr});
        mAddr = mAddr + 16'd1;
      end
    end
  endfunction

  function automatic logic [65:0] obsVec();
    return {MemReq, MemAddr, InstrValid, InstructionBus, InstrPC};
  endfunction

  function automatic logic [65:0] expVec();
    logic [47:0] head;
    head = '0;
    if (mQ.size() > 0) head = mQ[0];
    return {expReq(), mAddr, (mQ.size() > 0), head};
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus(input bit ack, input bit jmp, input logic [15:0] ja, input bit dec);
    MemAck = ack; JumpEn = jmp; JumpAddr = ja; DecReady = dec;
    MemData = {16'h0, MemAddr} + 32'h100;
    @(posedge clk);
    modelEdge(ack, jmp, ja, dec);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1; MemAck = 0; JumpEn = 0; DecReady = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checkCnt++;
    if ({MemReq, MemAddr, InstrValid, InstructionBus, InstrPC} !== 66'h0)
      $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec(), 66'h0);
    else passCnt++;
    rst = 1'b0;
    modelReset();
    checkCnt++;
    if (MemReq !== 1'b0) $display("[TB] FAIL boot_no_req: got %b expected 0", MemReq);
    else passCnt++;
    applyStimulus(0, 0, 16'h0, 0);
    checkCnt++;
    if (MemReq !== 1'b1) $display("[TB] FAIL first_req: got %b expected 1", MemReq);
    else passCnt++;
  endtask

  task automatic test_streaming();
    doReset();
    applyStimulus(1, 0, 16'h0, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1, 0, 16'h0, 1);
      checkCnt++;
      if (InstructionBus !== 32'h100 + i || InstrPC !== 16'(i) || MemAddr !== 16'(i + 1) || InstrValid !== 1'b1)
        $display("[TB] FAIL stream_%0d: got bus=%h pc=%h addr=%h v=%b expected bus=%h pc=%h addr=%h v=1",
                 i, InstructionBus, InstrPC, MemAddr, InstrValid, 32'h100 + i, i, i + 1);
      else passCnt++;
    end
  endtask

  task automatic test_full_queue();
    int acks;
    acks = 0;
    doReset();
    applyStimulus(0, 0, 16'h0, 0);
    for (int i = 0; i < 5; i++) begin
      if (MemReq) acks++;
      applyStimulus(1, 0, 16'h0, 0);
    end
    checkCnt++;
    if (acks !== 2 || MemReq !== 1'b0 || InstrPC !== 16'h0)
      $display("[TB] FAIL full_stop: got acks=%0d req=%b pc=%h expected acks=2 req=0 pc=0000", acks, MemReq, InstrPC);
    else passCnt++;
    applyStimulus(0, 0, 16'h0, 1);
    checkCnt++;
    if (MemReq !== 1'b1 || InstrPC !== 16'h1 || MemAddr !== 16'h2)
      $display("[TB] FAIL full_resume: got req=%b pc=%h addr=%h expected req=1 pc=0001 addr=0002", MemReq, InstrPC, MemAddr);
    else passCnt++;
  endtask

  task automatic test_delayed_ack();
    doReset();
    applyStimulus(0, 1, 16'h0005, 0);
    for (int i = 0; i < 4; i++) begin
      checkCnt++;
      if (MemReq !== 1'b1 || MemAddr !== 16'h0005 || InstrValid !== 1'b0)
        $display("[TB] FAIL wait_hold_%0d: got req=%b addr=%h v=%b expected req=1 addr=0005 v=0", i, MemReq, MemAddr, InstrValid);
      else passCnt++;
      if (i < 3) applyStimulus(0, 0, 16'h0, 1);
    end
    applyStimulus(1, 0, 16'h0, 0);
    checkCnt++;
    if (InstrValid !== 1'b1 || InstructionBus !== 32'h105 || InstrPC !== 16'h5 || MemAddr !== 16'h6)
      $display("[TB] FAIL wait_ack: got v=%b bus=%h pc=%h addr=%h expected v=1 bus=00000105 pc=0005 addr=0006",
               InstrValid, InstructionBus, InstrPC, MemAddr);
    else passCnt++;
  endtask

  task automatic test_jump_discard();
    doReset();
    applyStimulus(0, 1, 16'h0006, 0);
    applyStimulus(1, 0, 16'h0, 0);
    applyStimulus(0, 0, 16'h0, 0);
    applyStimulus(0, 1, 16'h0040, 0);
    checkCnt++;
    if (InstrValid !== 1'b0 || MemReq !== 1'b1 || MemAddr !== 16'h0007)
      $display("[TB] FAIL discard_enter: got v=%b req=%b addr=%h expected v=0 req=1 addr=0007", InstrValid, MemReq, MemAddr);
    else passCnt++;
    applyStimulus(1, 0, 16'h0, 0);
    checkCnt++;
    if (InstrValid !== 1'b0 || MemAddr !== 16'h0040)
      $display("[TB] FAIL discard_drop: got v=%b addr=%h expected v=0 addr=0040", InstrValid, MemAddr);
    else passCnt++;
    applyStimulus(1, 0, 16'h0, 0);
    checkCnt++;
    if (InstrValid !== 1'b1 || InstrPC !== 16'h0040 || InstructionBus !== 32'h140)
      $display("[TB] FAIL jump_target: got v=%b pc=%h bus=%h expected v=1 pc=0040 bus=00000140", InstrValid, InstrPC, InstructionBus);
    else passCnt++;
    applyStimulus(0, 1, 16'h0060, 1);
    applyStimulus(0, 1, 16'h0070, 0);
    applyStimulus(1, 0, 16'h0, 0);
    applyStimulus(1, 0, 16'h0, 0);
    checkCnt++;
    if (InstrPC !== 16'h0070 || InstrValid !== 1'b1 || MemAddr !== 16'h0071)
      $display("[TB] FAIL last_jump_wins: got pc=%h v=%b addr=%h expected pc=0070 v=1 addr=0071", InstrPC, InstrValid, MemAddr);
    else passCnt++;
  endtask

  task automatic test_wrap_and_reset();
    doReset();
    applyStimulus(0, 1, 16'hFFFF, 0);
    applyStimulus(1, 0, 16'h0, 1);
    checkCnt++;
    if (MemAddr !== 16'h0000 || InstrPC !== 16'hFFFF || InstructionBus !== 32'h100FF)
      $display("[TB] FAIL addr_wrap: got addr=%h pc=%h bus=%h expected addr=0000 pc=ffff bus=000100ff", MemAddr, InstrPC, InstructionBus);
    else passCnt++;
    applyStimulus(0, 0, 16'h0, 0);
    #2 rst = 1'b1;
    #1;
    checkCnt++;
    if (obsVec() !== 66'h0) $display("[TB] FAIL midwait_reset: got %h expected %h", obsVec(), 66'h0);
    else passCnt++;
    MemAck = 1'b1;
    MemData = 32'hDEADBEEF;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(1, 0, 16'h0, 0);
    checkCnt++;
    if (InstrValid !== 1'b0 || MemReq !== 1'b1 || MemAddr !== 16'h0000)
      $display("[TB] FAIL stale_ack: got v=%b req=%b addr=%h expected v=0 req=1 addr=0000", InstrValid, MemReq, MemAddr);
    else passCnt++;
  endtask

  task automatic test_random();
    logic [15:0] ja;
    doReset();
    for (int i = 0; i < 400; i++) begin
      ja = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFE + $urandom_range(0, 1)) : 16'($urandom);
      applyStimulus($urandom_range(0, 99) < 65, $urandom_range(0, 99) < 8, ja, $urandom_range(0, 99) < 60);
      checkCnt++;
      if (obsVec() !== expVec())
        $display("[TB] FAIL random_%0d: got %h expected %h", i, obsVec(), expVec());
      else passCnt++;
    end
  endtask

`ifdef IFU_STALL_CNT_EN
  task automatic test_stall_count();
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 16'h0, 1);
    checkCnt++;
    if (StallCnt !== 16'd10 || mStall != 10)
      $display("[TB] FAIL stall_count: got %0d expected 10", StallCnt);
    else passCnt++;
    applyStimulus(0, 1, 16'h0020, 1);
    checkCnt++;
    if (StallCnt !== 16'd0) $display("[TB] FAIL stall_clear: got %0d expected 0", StallCnt);
    else passCnt++;
  endtask
`endif

  initial begin
    modelReset();
    test_reset();
    test_streaming();
    test_full_queue();
    test_delayed_ack();
    test_jump_discard();
    test_wrap_and_reset();
    test_random();
`ifdef IFU_STALL_CNT_EN
    test_stall_count();
`endif
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
